rtc_register_file: RTL and testbench

- Parametrised register file behind the I2C slave for RTC-style peripherals (DS1307 class).
- Holds an internal register pointer with auto-increment and wrap.
- Exposes N live time/status registers from the RTC core, a battery-backed NVRAM region and two read-only ID bytes at the top of the address map.
- Forwards host writes to time registers to the RTC core as single-cycle strobes.

---
 rtl/rtc_register_file.sv | 124 ++++++++++++
 tb/tb_rtc_register_file.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_register_file.sv
// rtl/rtc_register_file.sv - RTC register file: auto-increment pointer, time window, NVRAM, ID bytes
// Optional feature macro: RTC_SNAPSHOT_EN (coherent time shadow captured on snap)
module rtc_register_file #(
  parameter int         ADDR_W    = 6,
  parameter int         TIME_REGS = 8,
  parameter logic [7:0] ID0       = 8'h5A,
  parameter logic [7:0] ID1       = 8'h58
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ptr_load,
  input  logic [ADDR_W-1:0]      ptr_data,
  input  logic                   wr_en,
  input  logic [7:0]             data_in,
  input  logic                   rd_ack,
  input  logic                   snap,
  input  logic [8*TIME_REGS-1:0] time_live,
  output logic [7:0]             data_out,
  output logic [ADDR_W-1:0]      ptr,
  output logic                   time_wr,
  output logic [ADDR_W-1:0]      time_wr_addr,
  output logic [7:0]             time_wr_data
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TIME_END = ADDR_W'(TIME_REGS);
  localparam logic [ADDR_W-1:0] NV_LAST  = ADDR_W'(DEPTH - 3);
  localparam logic [ADDR_W-1:0] ID0_ADDR = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] ID1_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_next;
  logic              wr_time;
  logic              wr_nv;
  logic [7:0]        rd_data;
  logic [7:0]        nvram     [DEPTH];
  logic [7:0]        time_view [DEPTH];

  // A load wins over any increment; write and ack together still advance only once
  always_comb begin
    ptr_next = ptr;
    if (ptr_load)
      ptr_next = ptr_data;
    else if (wr_en || rd_ack)
      ptr_next = ptr + 1'b1;
  end

  assign wr_time = wr_en && !ptr_load && (ptr < TIME_END);
  assign wr_nv   = wr_en && !ptr_load && (ptr >= TIME_END) && (ptr <= NV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      time_wr      <= 1'b0;
      time_wr_addr <= '0;
      time_wr_data <= '0;
    end else begin
      ptr     <= ptr_next;
      time_wr <= wr_time;
      if (wr_time) begin
        time_wr_addr <= ptr;
        time_wr_data <= data_in;
      end
    end
  end

  // Battery-backed contents survive reset
  always_ff @(posedge clk) begin
    if (wr_nv)
      nvram[ptr] <= data_in;
  end

`ifdef RTC_SNAPSHOT_EN
  logic [7:0] shadow [TIME_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TIME_REGS; k++)
        shadow[k] <= '0;
    end else if (snap) begin
      for (int k = 0; k < TIME_REGS; k++)
        shadow[k] <= (wr_time && ptr == ADDR_W'(k)) ? data_in : time_live[8*k +: 8];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    if (k < TIME_REGS) begin : g_time
      assign time_view[k] = shadow[k];
    end else begin : g_pad
      assign time_view[k] = '0;
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap;

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    if (k < TIME_REGS) begin : g_time
      assign time_view[k] = time_live[8*k +: 8];
    end else begin : g_pad
      assign time_view[k] = '0;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    if (ptr_next < TIME_END)
      rd_data = time_view[ptr_next];
    else if (ptr_next == ID0_ADDR)
      rd_data = ID0;
    else if (ptr_next == ID1_ADDR)
      rd_data = ID1;
    else
      rd_data = nvram[ptr_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_out <= '0;
    else
      data_out <= rd_data;
  end

endmodule

// File: tb/tb_rtc_register_file.sv
// tb/tb_rtc_register_file.sv - vector table with scoreboard queue for rtc_register_file
module tb_rtc_register_file;

`ifdef RTC_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ptr_load;
  logic [5:0]  ptr_data;
  logic        wr_en;
  logic [7:0]  data_in;
  logic        rd_ack;
  logic        snap;
  logic [63:0] time_live;
  logic [7:0]  data_out;
  logic [5:0]  ptr;
  logic        time_wr;
  logic [5:0]  time_wr_addr;
  logic [7:0]  time_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       load;
    logic [5:0] pdata;
    logic       wr;
    logic [7:0] din;
    logic       ack;
    logic       snp;
    logic [5:0] eptr;
    logic       chk_do;
    logic [7:0] edo;
    logic       etwr;
    logic [5:0] etwa;
    logic [7:0] etwd;
  } vec_t;

  vec_t vecs [35];
  vec_t sb [$];

  rtc_register_file dut (
    .clk          (clk),
    .rst          (rst),
    .ptr_load     (ptr_load),
    .ptr_data     (ptr_data),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_ack       (rd_ack),
    .snap         (snap),
    .time_live    (time_live),
    .data_out     (data_out),
    .ptr          (ptr),
    .time_wr      (time_wr),
    .time_wr_addr (time_wr_addr),
    .time_wr_data (time_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic load, input logic [5:0] pdata, input logic wr,
                              input logic [7:0] din, input logic ack, input logic snp,
                              input logic [5:0] eptr, input logic chk_do, input logic [7:0] edo,
                              input logic etwr, input logic [5:0] etwa, input logic [7:0] etwd);
    vec_t v;
    v.load = load; v.pdata = pdata; v.wr = wr; v.din = din; v.ack = ack; v.snp = snp;
    v.eptr = eptr; v.chk_do = chk_do; v.edo = edo; v.etwr = etwr; v.etwa = etwa; v.etwd = etwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    ptr_load = v.load;
    ptr_data = v.pdata;
    wr_en    = v.wr;
    data_in  = v.din;
    rd_ack   = v.ack;
    snap     = v.snp;
    sb.push_back(v);
    @(posedge clk);
    #1;
    ptr_load = 1'b0;
    wr_en    = 1'b0;
    rd_ack   = 1'b0;
    snap     = 1'b0;
    e = sb.pop_front();
    chk("ptr", 32'(ptr), 32'(e.eptr));
    if (e.chk_do)
      chk("data_out", 32'(data_out), 32'(e.edo));
    chk("time_wr", 32'(time_wr), 32'(e.etwr));
    if (e.etwr) begin
      chk("time_wr_addr", 32'(time_wr_addr), 32'(e.etwa));
      chk("time_wr_data", 32'(time_wr_data), 32'(e.etwd));
    end
  endtask

  initial begin
    //            ld pdata wr din    ack snp  eptr  chk edo                    twr twa   twd
    vecs[0]  = mk(1, 6'h08, 0, 8'h00, 0, 0, 6'h08, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[1]  = mk(0, 6'h00, 1, 8'hA1, 0, 0, 6'h09, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[2]  = mk(0, 6'h00, 1, 8'hA2, 0, 0, 6'h0A, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[3]  = mk(0, 6'h00, 1, 8'hA3, 0, 0, 6'h0B, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[4]  = mk(1, 6'h08, 0, 8'h00, 0, 0, 6'h08, 1, 8'hA1,                 0, 6'h0, 8'h00);
    vecs[5]  = mk(0, 6'h00, 0, 8'h00, 1, 0, 6'h09, 1, 8'hA2,                 0, 6'h0, 8'h00);
    vecs[6]  = mk(0, 6'h00, 0, 8'h00, 1, 0, 6'h0A, 1, 8'hA3,                 0, 6'h0, 8'h00);
    vecs[7]  = mk(0, 6'h00, 0, 8'h00, 1, 0, 6'h0B, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[8]  = mk(1, 6'h3D, 0, 8'h00, 0, 0, 6'h3D, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[9]  = mk(0, 6'h00, 1, 8'h77, 0, 0, 6'h3E, 1, 8'h5A,                 0, 6'h0, 8'h00);
    vecs[10] = mk(0, 6'h00, 0, 8'h00, 1, 0, 6'h3F, 1, 8'h58,                 0, 6'h0, 8'h00);
    vecs[11] = mk(0, 6'h00, 0, 8'h00, 1, 0, 6'h00, 1, SNAP ? 8'h00 : 8'h30,  0, 6'h0, 8'h00);
    vecs[12] = mk(1, 6'h3D, 0, 8'h00, 0, 0, 6'h3D, 1, 8'h77,                 0, 6'h0, 8'h00);
    vecs[13] = mk(1, 6'h3E, 0, 8'h00, 0, 0, 6'h3E, 1, 8'h5A,                 0, 6'h0, 8'h00);
    vecs[14] = mk(0, 6'h00, 1, 8'hFF, 0, 0, 6'h3F, 1, 8'h58,                 0, 6'h0, 8'h00);
    vecs[15] = mk(1, 6'h3E, 0, 8'h00, 0, 0, 6'h3E, 1, 8'h5A,                 0, 6'h0, 8'h00);
    vecs[16] = mk(1, 6'h02, 0, 8'h00, 0, 0, 6'h02, 1, SNAP ? 8'h00 : 8'h32,  0, 6'h0, 8'h00);
    vecs[17] = mk(0, 6'h00, 1, 8'h45, 1, 0, 6'h03, 1, SNAP ? 8'h00 : 8'h33,  1, 6'h2, 8'h45);
    vecs[18] = mk(0, 6'h00, 0, 8'h00, 0, 0, 6'h03, 1, SNAP ? 8'h00 : 8'h33,  0, 6'h0, 8'h00);
    vecs[19] = mk(1, 6'h10, 0, 8'h00, 0, 0, 6'h10, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[20] = mk(0, 6'h00, 1, 8'h11, 0, 0, 6'h11, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[21] = mk(1, 6'h10, 1, 8'hEE, 0, 0, 6'h10, 1, 8'h11,                 0, 6'h0, 8'h00);
    vecs[22] = mk(0, 6'h00, 0, 8'h00, 0, 0, 6'h10, 1, 8'h11,                 0, 6'h0, 8'h00);
    vecs[23] = mk(1, 6'h14, 0, 8'h00, 0, 0, 6'h14, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[24] = mk(0, 6'h00, 1, 8'h5B, 0, 0, 6'h15, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[25] = mk(0, 6'h00, 1, 8'h5C, 0, 0, 6'h16, 0, 8'h00,                 0, 6'h0, 8'h00);
    vecs[26] = mk(1, 6'h15, 0, 8'h00, 0, 0, 6'h15, 1, 8'h5C,                 0, 6'h0, 8'h00);
    // after the mid-burst reset
    vecs[27] = mk(1, 6'h14, 0, 8'h00, 0, 0, 6'h14, 1, 8'h5B,                 0, 6'h0, 8'h00);
    vecs[28] = mk(0, 6'h00, 0, 8'h00, 1, 0, 6'h15, 1, 8'h5C,                 0, 6'h0, 8'h00);
    // snapshot with byte0 live = 0x59, then byte0 live = 0x00
    vecs[29] = mk(0, 6'h00, 0, 8'h00, 0, 1, 6'h15, 1, 8'h5C,                 0, 6'h0, 8'h00);
    vecs[30] = mk(1, 6'h00, 0, 8'h00, 0, 0, 6'h00, 1, SNAP ? 8'h59 : 8'h00,  0, 6'h0, 8'h00);
    vecs[31] = mk(1, 6'h01, 0, 8'h00, 0, 0, 6'h01, 1, 8'h31,                 0, 6'h0, 8'h00);
    vecs[32] = mk(0, 6'h00, 1, 8'h66, 0, 1, 6'h02, 1, 8'h32,                 1, 6'h1, 8'h66);
    vecs[33] = mk(1, 6'h01, 0, 8'h00, 0, 0, 6'h01, 1, SNAP ? 8'h66 : 8'h31,  0, 6'h0, 8'h00);
    vecs[34] = mk(1, 6'h00, 0, 8'h00, 0, 0, 6'h00, 1, 8'h00,                 0, 6'h0, 8'h00);

    rst = 1'b1;
    ptr_load = 1'b0; ptr_data = '0; wr_en = 1'b0; data_in = '0; rd_ack = 1'b0; snap = 1'b0;
    for (int k = 0; k < 8; k++)
      time_live[8*k +: 8] = 8'h30 + 8'(k);
    #12;
    chk("reset ptr", 32'(ptr), 32'h0);
    chk("reset data_out", 32'(data_out), 32'h0);
    chk("reset time_wr", 32'(time_wr), 32'h0);
    chk("reset time_wr_addr", 32'(time_wr_addr), 32'h0);
    chk("reset time_wr_data", 32'(time_wr_data), 32'h0);
    rst = 1'b0;

    for (int i = 0; i <= 26; i++)
      apply(vecs[i]);

    // asynchronous reset mid-burst at ptr 0x15, away from any clock edge
    rd_ack = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async rst ptr", 32'(ptr), 32'h0);
    chk("async rst data_out", 32'(data_out), 32'h0);
    chk("async rst time_wr", 32'(time_wr), 32'h0);
    #2;
    rst = 1'b0;
    rd_ack = 1'b0;

    for (int i = 27; i <= 28; i++)
      apply(vecs[i]);

    time_live[7:0] = 8'h59;
    apply(vecs[29]);
    time_live[7:0] = 8'h00;
    for (int i = 30; i <= 34; i++)
      apply(vecs[i]);

    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
